// File: rtl/writer.sv
// Output side of the cipher host interface: buffers datapath byte pulses in a FIFO and
// presents each byte to the pins with a 4-phase request/acknowledge handshake.
module writer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_byte,
  input  logic       data_pulse,
  output logic       writer_ready,
  output logic [7:0] output_byte,
  output logic       output_request,
  input  logic       output_acknowledge,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0]   CntOne = 1;
  localparam logic [PtrW:0]   CntFull = (PtrW+1)'(DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLoad    = 2'd1;
  localparam logic [1:0] StReq     = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  logic [7:0]             mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]          count_q, count_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [1:0]             state_q, state_d;
  logic [7:0]             byte_q, byte_d;
  logic                   req_q, req_d;
  logic                   ovf_q;
  logic                   push, pop;

  assign ack_s        = sync_q[SYNC_STAGES-1];
  assign writer_ready = (count_q != CntFull);
  assign push         = data_pulse && writer_ready;
  // REQ is only reachable with the head still queued, so count >= 1 here.
  assign pop          = (state_q == StReq) && ack_s;

  assign output_byte    = byte_q;
  assign output_request = req_q;
  assign overflow       = ovf_q;
  assign busy           = (state_q != StIdle) || (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    req_d   = req_q;
    case (state_q)
      StIdle: begin
        if ((count_q != '0) && !ack_s) begin
          state_d = StLoad;
          byte_d  = mem_q[rd_ptr_q];
        end
      end
      StLoad: begin
        if (!ack_s) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        if (ack_s) begin
          state_d = StRelease;
          req_d   = 1'b0;
        end
      end
      StRelease: begin
        if (!ack_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sync_q   <= '0;
      state_q  <= StIdle;
      byte_q   <= 8'h00;
      req_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], output_acknowledge};
      count_q <= count_d;
      state_q <= state_d;
      byte_q  <= byte_d;
      req_q   <= req_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (data_pulse && !writer_ready) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writer.sv
// Self-checking bench for writer: a host model answers the handshake, a monitor captures
// each presented byte, and expected bytes are queued at push time and compared in order.
module tb_writer;

  localparam int unsigned Depth = 4;
  localparam int unsigned SyncStages = 2;

  logic       clk;
  logic       rst;
  logic [7:0] data_byte;
  logic       data_pulse;
  logic       writer_ready;
  logic [7:0] output_byte;
  logic       output_request;
  logic       output_acknowledge;
  logic       overflow;
  logic       busy;

  logic force_ack_en;
  logic force_ack_val;
  logic host_ack;
  logic host_en;
  int   host_delay;
  int   hcnt;
  logic req_prev;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  int checks;
  int failures;

  writer #(
    .DEPTH      (Depth),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .data_byte         (data_byte),
    .data_pulse        (data_pulse),
    .writer_ready      (writer_ready),
    .output_byte       (output_byte),
    .output_request    (output_request),
    .output_acknowledge(output_acknowledge),
    .overflow          (overflow),
    .busy              (busy)
  );

  assign output_acknowledge = force_ack_en ? force_ack_val : host_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host: acknowledge host_delay cycles after seeing request, release after request drops.
  initial begin
    host_ack = 1'b0;
    hcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        host_ack = 1'b0;
        hcnt = 0;
      end else if (host_en) begin
        if (!host_ack && output_request) begin
          if (hcnt >= host_delay) begin
            host_ack = 1'b1;
            hcnt = 0;
          end else begin
            hcnt++;
          end
        end else if (host_ack && !output_request) begin
          host_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: record the byte presented on every request rising edge.
  initial begin
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0;
      end else begin
        if (output_request && !req_prev) rx_q.push_back(output_byte);
        req_prev = output_request;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_byte  = b;
    data_pulse = 1'b1;
    tick();
    data_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic wait_drain(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rx_q.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] b;
    rst = 1'b1;
    #2;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (output_byte !== 8'h00) begin
      failures++;
      $display("FAIL reset_byte got=%h want=00", output_byte);
    end
    checks++;
    if (output_request !== 1'b0) begin
      failures++;
      $display("FAIL reset_request got=%b want=0", output_request);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow got=%b want=0", overflow);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (writer_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", writer_ready);
    end
    // Three bytes queued, handshake parked in REQ, then reset mid-cycle.
    host_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = 8'h31 + 8'(i);
      push_byte(b);
    end
    for (int i = 0; i < 10 && !output_request; i++) tick();
    checks++;
    if (output_request !== 1'b1) begin
      failures++;
      $display("FAIL midreq_request got=%b want=1", output_request);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (output_request !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_request got=%b want=0", output_request);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (writer_ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL post_reset ready=%b busy=%b ovf=%b want 1/0/0", writer_ready, busy,
               overflow);
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_single_byte();
    logic [7:0] e;
    logic [7:0] r;
    force_ack_en  = 1'b1;
    force_ack_val = 1'b0;
    push_byte(8'hA5);  // now just after E0
    exp_q.push_back(8'hA5);
    tick();            // E0+1
    checks++;
    if (output_byte !== 8'hA5 || output_request !== 1'b0) begin
      failures++;
      $display("FAIL single_load byte=%h req=%b want A5/0", output_byte, output_request);
    end
    tick();            // E0+2
    checks++;
    if (output_request !== 1'b1) begin
      failures++;
      $display("FAIL single_req_rise got=%b want=1", output_request);
    end
    tick();
    tick();
    tick();            // E0+5
    force_ack_val = 1'b1;
    tick();
    tick();            // E0+7: ack still inside the synchroniser
    checks++;
    if (output_request !== 1'b1) begin
      failures++;
      $display("FAIL single_req_hold got=%b want=1", output_request);
    end
    tick();            // E0+8
    checks++;
    if (output_request !== 1'b0) begin
      failures++;
      $display("FAIL single_req_fall got=%b want=0", output_request);
    end
    force_ack_val = 1'b0;
    tick();
    tick();            // E0+10
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_release got=%b want=1", busy);
    end
    tick();            // E0+11
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_idle got=%b want=0", busy);
    end
    checks++;
    if (rx_q.size() != 1) begin
      failures++;
      $display("FAIL single_count got=%0d want=1", rx_q.size());
    end else begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      if (r !== e) begin
        failures++;
        $display("FAIL single_data got=%h want=%h", r, e);
      end
    end
    force_ack_en = 1'b0;
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_burst();
    logic [7:0] pat [4];
    logic [7:0] e;
    logic [7:0] r;
    bit ok;
    do_reset();
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    host_en = 1'b1;
    host_delay = 1;
    for (int i = 0; i < 4; i++) begin
      data_byte  = pat[i];
      data_pulse = 1'b1;
      exp_q.push_back(pat[i]);
      tick();
    end
    data_pulse = 1'b0;
    checks++;
    if (writer_ready !== 1'b0) begin
      failures++;
      $display("FAIL burst_full_ready got=%b want=0", writer_ready);
    end
    wait_drain(4, ok);
    checks++;
    if (!ok || rx_q.size() != 4) begin
      failures++;
      $display("FAIL burst_drain got=%0d bytes want=4", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL burst_data got=%h want=%h", r, e);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL burst_overflow got=%b want=0", overflow);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    logic [7:0] e;
    logic [7:0] r;
    int mcount;
    bit ok;
    do_reset();
    host_en = 1'b0;
    mcount = 0;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      data_byte  = b;
      data_pulse = 1'b1;
      if (mcount < Depth) begin
        exp_q.push_back(b);
        mcount++;
      end
      tick();
    end
    data_pulse = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag got=%b want=1", overflow);
    end
    host_en = 1'b1;
    host_delay = 0;
    wait_drain(4, ok);
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (!ok || rx_q.size() != 4) begin
      failures++;
      $display("FAIL ovf_count got=%0d bytes want=4", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL ovf_data got=%h want=%h", r, e);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b want=1", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [7:0] r;
    bit ok;
    do_reset();
    host_en = 1'b0;
    force_ack_en  = 1'b1;
    force_ack_val = 1'b0;
    push_byte(8'hC1);
    push_byte(8'hC2);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    for (int i = 0; i < 10 && !output_request; i++) tick();
    force_ack_val = 1'b1;   // just after Pk
    tick();
    tick();                 // Pk+2: pop happens at next edge
    data_byte  = 8'h77;
    data_pulse = 1'b1;
    exp_q.push_back(8'h77);
    tick();                 // Pk+3
    data_pulse = 1'b0;
    checks++;
    if (output_request !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_req got=%b want=0", output_request);
    end
    checks++;
    if (dut.count_q !== 3'd2) begin
      failures++;
      $display("FAIL pushpop_count got=%0d want=2", dut.count_q);
    end
    force_ack_val = 1'b0;
    force_ack_en  = 1'b0;
    host_en = 1'b1;
    host_delay = 2;
    wait_drain(3, ok);
    checks++;
    if (!ok || rx_q.size() != 3) begin
      failures++;
      $display("FAIL pushpop_drain got=%0d bytes want=3", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL pushpop_data got=%h want=%h", r, e);
      end
    end
  endtask

  task automatic test_host_violation();
    logic [7:0] e;
    logic [7:0] r;
    bit ok;
    bit early;
    do_reset();
    host_en = 1'b0;
    force_ack_en  = 1'b1;
    force_ack_val = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    push_byte(8'h5A);
    exp_q.push_back(8'h5A);
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (output_request !== 1'b0) early = 1'b1;
      tick();
    end
    checks++;
    if (early || output_request !== 1'b0) begin
      failures++;
      $display("FAIL viol_no_req got=%b want=0", early | output_request);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL viol_busy got=%b want=1", busy);
    end
    force_ack_val = 1'b0;   // just after Pk
    tick();
    tick();                 // Pk+2: low ack not yet through the synchroniser
    checks++;
    if (output_request !== 1'b0) begin
      failures++;
      $display("FAIL viol_req_early got=%b want=0", output_request);
    end
    tick();
    tick();                 // Pk+4
    checks++;
    if (output_request !== 1'b1 || output_byte !== 8'h5A) begin
      failures++;
      $display("FAIL viol_req_rise req=%b byte=%h want 1/5A", output_request, output_byte);
    end
    force_ack_en = 1'b0;
    host_en = 1'b1;
    host_delay = 1;
    wait_drain(1, ok);
    checks++;
    if (!ok || rx_q.size() != 1) begin
      failures++;
      $display("FAIL viol_drain got=%0d bytes want=1", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL viol_data got=%h want=%h", r, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    data_byte = 8'h00;
    data_pulse = 1'b0;
    force_ack_en = 1'b0;
    force_ack_val = 1'b0;
    host_en = 1'b0;
    host_delay = 1;
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_back_to_back();
    test_host_violation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
